// File: rtl/band_pkg.sv
// Shared types and default constants for the scroll band drawer.
package band_pkg;

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    NARROWING = 2'd1,
    NARROW    = 2'd2,
    WIDENING  = 2'd3
  } width_state_t;

  localparam int DEF_CENTER    = 120;
  localparam int DEF_OSC       = 30;
  localparam int DEF_WIDTH_MAX = 90;
  localparam int DEF_WIDTH_MIN = 40;
  localparam int DEF_LENGTH    = 512;

  // Band coordinates carry one spare bit so left + width never wraps.
  localparam int BAND_W = 11;

  // Triangle wave 0..63..0 across the table, used as the band offset.
  function automatic logic [5:0] tri_offset(input logic [15:0] a, input int aw);
    int n;
    int half;
    int p;
    int den;
    n    = 1 << aw;
    half = n / 2;
    p    = (int'(a) < half) ? int'(a) : (n - 1 - int'(a));
    den  = (half > 1) ? (half - 1) : 1;
    return 6'((p * 63) / den);
  endfunction

endpackage

// File: rtl/scroll_band_drawer_if.sv
// Raster-side bus of the scroll band drawer: pixel position and control in,
// band flags and current drawing width out.
interface scroll_band_drawer_if #(parameter int SPEED_W = 3) ();
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               update_signal;
  logic [SPEED_W-1:0] speed;
  logic               narrow_req;
  logic               is_on;
  logic               is_edge;
  logic [9:0]         width_out;

  modport master (
    output pixel_x, pixel_y, update_signal, speed, narrow_req,
    input  is_on, is_edge, width_out
  );

  modport slave (
    input  pixel_x, pixel_y, update_signal, speed, narrow_req,
    output is_on, is_edge, width_out
  );
endinterface

// File: rtl/band_offset_rom.sv
// Band offset table: 6-bit unsigned triangle wave, one-cycle registered read.
// TABLE_ZERO forces an all-zero table (flat band).
module band_offset_rom
  import band_pkg::*;
#(
  parameter int ROM_AW     = 8,
  parameter bit TABLE_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] addr,
  output logic [5:0]        data
);

  // Registered table read.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= 6'd0;
    end else if (TABLE_ZERO) begin
      data <= 6'd0;
    end else begin
      data <= tri_offset(16'(addr), ROM_AW);
    end
  end

endmodule

// File: rtl/scroll_band_drawer.sv
// Scrolling vertical band with animated width.
// Optional macro BAND_EDGE_EN builds the boundary-column detector (is_edge);
// without it is_edge is tied to 0.
module scroll_band_drawer
  import band_pkg::*;
#(
  parameter int CENTER     = DEF_CENTER,
  parameter int OSC        = DEF_OSC,
  parameter int WIDTH_MAX  = DEF_WIDTH_MAX,
  parameter int WIDTH_MIN  = DEF_WIDTH_MIN,
  parameter int LENGTH     = DEF_LENGTH,
  parameter int ROM_AW     = 8,
  parameter int SPEED_W    = 3,
  parameter bit TABLE_ZERO = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  scroll_band_drawer_if.slave bus
);

  localparam int CW = $clog2(LENGTH);

  logic [CW-1:0]      scroll_cnt;
  logic [SPEED_W-1:0] speed;
  width_state_t       state, state_next;
  logic [9:0]         width, width_next;
  logic [9:0]         draw_width;
  logic [9:0]         x_d1;
  logic [5:0]         offset;
  logic [BAND_W-1:0]  x_ext, left, right;
  logic               on_q;
  logic               edge_q;

  assign speed = bus.speed;

  // Scroll position steps backwards by speed on each update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_cnt <= '0;
    end else if (bus.update_signal) begin
      scroll_cnt <= scroll_cnt - CW'(speed);
    end
  end

  band_offset_rom #(
    .ROM_AW     (ROM_AW),
    .TABLE_ZERO (TABLE_ZERO)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (ROM_AW'(scroll_cnt + CW'(bus.pixel_y))),
    .data  (offset)
  );

  // Width FSM state and width registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STEADY;
      width <= 10'(WIDTH_MAX);
    end else begin
      state <= state_next;
      width <= width_next;
    end
  end

  // Width FSM: direction follows narrow_req every cycle; width only moves on
  // update strobes and saturates at the limits.
  always_comb begin
    state_next = state;
    width_next = width;
    case (state)
      STEADY: begin
        if (bus.narrow_req) state_next = NARROWING;
      end
      NARROWING: begin
        if (!bus.narrow_req) begin
          state_next = WIDENING;
        end else begin
          if (bus.update_signal && (width > 10'(WIDTH_MIN))) width_next = width - 10'd1;
          if (width_next == 10'(WIDTH_MIN)) state_next = NARROW;
        end
      end
      NARROW: begin
        if (!bus.narrow_req) state_next = WIDENING;
      end
      WIDENING: begin
        if (bus.narrow_req) begin
          state_next = NARROWING;
        end else begin
          if (bus.update_signal && (width < 10'(WIDTH_MAX))) width_next = width + 10'd1;
          if (width_next == 10'(WIDTH_MAX)) state_next = STEADY;
        end
      end
      default: state_next = STEADY;
    endcase
  end

  // Drawing width is latched only at frame start so a frame never tears;
  // a same-cycle update is not seen because width updates on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      draw_width <= 10'(WIDTH_MAX);
    end else if ((bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0)) begin
      draw_width <= width;
    end
  end

  assign x_ext = BAND_W'(x_d1);
  assign left  = BAND_W'(CENTER - OSC) + BAND_W'(offset)
               + ((BAND_W'(WIDTH_MAX) - BAND_W'(draw_width)) >> 1);
  assign right = left + BAND_W'(draw_width);

  // Stage 1 aligns x with the table read; stage 2 registers the band flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_d1 <= 10'd0;
      on_q <= 1'b0;
`ifdef BAND_EDGE_EN
      edge_q <= 1'b0;
`endif
    end else begin
      x_d1 <= bus.pixel_x;
      on_q <= (x_ext >= left) && (x_ext <= right);
`ifdef BAND_EDGE_EN
      edge_q <= (x_ext == left) || (x_ext == right);
`endif
    end
  end

`ifndef BAND_EDGE_EN
  assign edge_q = 1'b0;
`endif

  assign bus.is_on     = on_q;
  assign bus.is_edge   = edge_q;
  assign bus.width_out = draw_width;

endmodule
